tile_fetch_seq: RTL

TILE_FETCH_SEQ -- requirements
Module: tile_fetch_seq

---
 rtl/tile_fetch_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/tile_fetch_seq.sv
// tile_fetch_seq: per-line tile fetcher that reads tile codes from VRAM and plane bytes from ROM.
// It hands the plane bytes to a shifter pair on every 8th pixel.
module tile_fetch_seq #(
   parameter int COLS = 32
) (
   input  logic        clk,
   input  logic        n_clr,
   input  logic        cen,
   input  logic        line_start,
   input  logic [7:0]  vpos,
   output logic [9:0]  vram_addr,
   output logic        vram_rd,
   input  logic [15:0] vram_data,
   output logic [13:0] rom_addr,
   output logic        rom_rd,
   input  logic        rom_ok,
   input  logic [15:0] rom_data,
   output logic [7:0]  d1_out,
   output logic [7:0]  d2_out,
   output logic        shift_ld,
   output logic        sel,
   output logic [3:0]  pal_out,
   output logic        fetch_miss,
   output logic        active
);
   localparam logic [2:0] S_IDLE = 3'd0, S_VREQ = 3'd1, S_VCAP = 3'd2, S_RREQ = 3'd3, S_DONE = 3'd4;
   logic [2:0] st;
   logic [2:0] pix;
   logic [4:0] col;
   logic [7:0] s1, s2;
   logic [3:0] pal_q;
   logic       flip;
   logic       start, load, go, last;
   assign start = line_start & cen;
   assign load = active & (pix == 3'd7) & cen & ~line_start;
   assign go = cen & active & (pix == 3'd0) & ({1'b0, col} < 6'(COLS));
   assign last = col == 5'(COLS - 1);
   assign vram_rd = st == S_VREQ;
   assign rom_rd = st == S_RREQ;
   assign shift_ld = ~load;
   assign sel = flip;
   assign d1_out = st == S_DONE ? s1 : 8'h00;
   assign d2_out = st == S_DONE ? s2 : 8'h00;
   // Addresses are registered so they read zero in reset and stay stable through each request.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         st <= S_IDLE;
         pix <= 3'd0;
         col <= 5'd0;
         active <= 1'b0;
         vram_addr <= 10'd0;
         rom_addr <= 14'd0;
         s1 <= 8'h00;
         s2 <= 8'h00;
         pal_q <= 4'h0;
         flip <= 1'b0;
         pal_out <= 4'h0;
         fetch_miss <= 1'b0;
      end else begin
         fetch_miss <= load && st != S_DONE;
         if (start) begin
            active <= 1'b1;
            pix <= 3'd0;
            col <= 5'd0;
            st <= S_VREQ;
            vram_addr <= {vpos[7:3], 5'd0};
         end else begin
            if (cen && active) pix <= pix + 3'd1;
            if (load) begin
               col <= col + 5'd1;
               pal_out <= pal_q;
               st <= S_IDLE;
               if (last) active <= 1'b0;
            end else begin
               case (st)
                  S_IDLE: if (go) begin
                     st <= S_VREQ;
                     vram_addr <= {vpos[7:3], col};
                  end
                  S_VREQ: st <= S_VCAP;
                  S_VCAP: begin
                     rom_addr <= {vram_data[10:0], vpos[2:0]};
                     flip <= vram_data[11];
                     pal_q <= vram_data[15:12];
                     st <= S_RREQ;
                  end
                  S_RREQ: if (rom_ok) begin
                     s1 <= rom_data[7:0];
                     s2 <= rom_data[15:8];
                     st <= S_DONE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule
